des_expand_pipe: RTL
====================

Name: des_expand_pipe

Overview:
- Parametrised, pipelined successor to the DES E expansion.
- Expands a HALF_W-bit right half into OUT_W bits: each SEG-bit segment is widened by its two cyclic neighbour bits.
- Optionally XORs the round subkey into the result, then carries it through a DEPTH-stage elastic valid/ready pipeline.
- Sits between round-key selection and the S-box stage of the round datapath.

Parameters:
- HALF_W, 32, input half-block width; must be a multiple of SEG.
- SEG, 4, segment width; each segment yields SEG+2 output bits.
- DEPTH, 2, pipeline register stages, >=1; also the latency.
- TAG_W, 4, sideband tag width, passed through unchanged.
- OUT_W (localparam) = (HALF_W/SEG)*(SEG+2); 48 at defaults.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  input word valid.
- in_ready  out  1  input accepted when in_valid && in_ready.
- data_in  in  HALF_W+1  bits [HALF_W:1] used; bit 0 unused and ignored.
- key_in  in  OUT_W+1  bits [OUT_W:1] used; bit 0 ignored.
- mix_en  in  1  1 = XOR key_in into the expansion; 0 = pure expansion.
- tag_in  in  TAG_W  sideband tag.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accept.
- data_out  out  OUT_W+1  bits [OUT_W:1] are the result; bit 0 is always 0.
- tag_out  out  TAG_W  tag that travelled with data_out.
- busy  out  1  OR of all stage valid bits.
- par_out  out  1  present only with DES_EXP_PARITY_EN.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Expansion, for segment j = 0..HALF_W/SEG-1, with base o = j*(SEG+2):
  - out[o+1] = in[((j*SEG+HALF_W-1) mod HALF_W)+1]
  - out[o+1+k] = in[j*SEG+k] for k = 1..SEG
  - out[o+SEG+2] = in[(((j+1)*SEG) mod HALF_W)+1]
  - At defaults this reproduces the DES E table: out[1] = in[32], out[48] = in[1].
- Mix: stage-1 word = expansion XOR (mix_en ? key_in[OUT_W:1] : 0). mix_en, key_in and tag_in are sampled in the accept cycle only.
- Pipeline:
  - Stage i holds valid_i, data_i and tag_i.
  - Stage i loads when !valid_i or stage i+1 loads this cycle. For the last stage, "stage i+1 loads" means out_ready.
  - in_ready = stage-1 load condition; it is a combinational ready chain with no bubbles.
  - Latency is DEPTH cycles from accept to out_valid. Throughput is 1 word/cycle when out_ready is held 1.
  - Order is preserved. There is no drop and no duplication.
- Backpressure: while out_valid && !out_ready, data_out and tag_out hold stable. With all DEPTH stages full, in_ready = 0 in the same cycle.
- Simultaneous events: a full pipe with out_ready = 1 and in_valid = 1 accepts and emits in the same cycle.
- Reset (synchronous, active-high, rst):
  - All valid bits, data and tag registers clear to 0.
  - out_valid = 0, data_out = 0, tag_out = 0, busy = 0, par_out = 0.
  - in_ready = 0 while rst is high and 1 in the first cycle after.
  - Reset mid-operation discards all in-flight words; no partial output appears.
- busy = 1 from the cycle after accept until the last word leaves.

Optional Feature:
- Macro: DES_EXP_PARITY_EN.
- Defined:
  - Port par_out exists; it is registered alongside data in every stage.
  - par_out = XOR of the stage-1 word bits [OUT_W:1], i.e. even parity, computed at accept.
  - par_out travels with its word and is stable under backpressure.
- Undefined: par_out port and its registers are absent; all other behaviour is identical.

Test Plan:
- Reset, then data_in with only in[32] = 1, mix_en = 0 -> after DEPTH = 2 cycles, data_out has only bits 1 and 47 set.
- Only in[1] = 1 gives bits 2 and 48. Only in[5] = 1 gives bits 6 and 8.
- data_in = 0, key_in[48:1] all ones, tag = 0x5:
  - mix_en = 1 -> data_out[48:1] all ones, tag_out = 0x5.
  - mix_en = 0 -> data_out = 0.
- data_in[32:1] all ones, key_in = 0 -> data_out[48:1] all ones. With DES_EXP_PARITY_EN, par_out = 0 (48 ones).
- DEPTH = 2, out_ready = 0, offer words tagged 1, 2, 3 back-to-back:
  - Tags 1 and 2 are accepted; in_ready = 0 while tag 3 waits.
  - Raise out_ready -> tags 1, 2, 3 emerge on consecutive cycles, in order.
- Streaming 10 words with out_ready = 1, then assert rst for 1 cycle at word 6:
  - out_valid = 0 and busy = 0 in the cycle after reset; no pre-reset word emerges afterwards.
  - The next accepted word appears DEPTH cycles later.
- HALF_W = 16, SEG = 4 (OUT_W = 24), only in[16] = 1 -> data_out bits 1 and 23 set.

Source files
------------

// File: rtl/des_expand_pipe.sv
// DES E-style expansion with optional subkey mix, carried through a DEPTH-stage valid/ready pipeline.
// Optional parity sideband is enabled with the DES_EXP_PARITY_EN macro.
module des_expand_pipe #(
  parameter int HALF_W = 32,
  parameter int SEG    = 4,
  parameter int DEPTH  = 2,
  parameter int TAG_W  = 4,
  localparam int OUT_W = (HALF_W / SEG) * (SEG + 2)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [HALF_W:0]    data_in,
  input  logic [OUT_W:0]     key_in,
  input  logic               mix_en,
  input  logic [TAG_W-1:0]   tag_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W:0]     data_out,
  output logic [TAG_W-1:0]   tag_out,
  output logic               busy
`ifdef DES_EXP_PARITY_EN
  ,
  output logic               par_out
`endif
);

  localparam int NSEG = HALF_W / SEG;

  logic [OUT_W:1]     exp_w;
  logic [OUT_W:1]     mix_w;

  logic [DEPTH-1:0]   valid_q;
  logic [DEPTH-1:0]   valid_d;
  logic [DEPTH-1:0]   load;
  logic [OUT_W:1]     data_q [DEPTH];
  logic [OUT_W:1]     data_d [DEPTH];
  logic [TAG_W-1:0]   tag_q  [DEPTH];
  logic [TAG_W-1:0]   tag_d  [DEPTH];
`ifdef DES_EXP_PARITY_EN
  logic [DEPTH-1:0]   par_q;
  logic [DEPTH-1:0]   par_d;
`endif

  // Bit 0 of data_in/key_in is unused; buses keep 1-based bit numbering.
  logic unused_bits;
  assign unused_bits = data_in[0] ^ key_in[0];

  always_comb begin
    exp_w = '0;
    for (int j = 0; j < NSEG; j++) begin
      exp_w[j*(SEG+2)+1] = data_in[((j*SEG+HALF_W-1) % HALF_W)+1];
      for (int k = 1; k <= SEG; k++) begin
        exp_w[j*(SEG+2)+1+k] = data_in[j*SEG+k];
      end
      exp_w[j*(SEG+2)+SEG+2] = data_in[(((j+1)*SEG) % HALF_W)+1];
    end
  end

  assign mix_w = exp_w ^ (mix_en ? key_in[OUT_W:1] : '0);

  // Ready ripples back from out_ready so a full pipe can accept and emit in one cycle.
  always_comb begin
    logic ld;
    ld   = out_ready;
    load = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      ld      = ~valid_q[i] | ld;
      load[i] = ld;
    end
  end

  assign in_ready = load[0] & ~rst;

  always_comb begin
    valid_d[0] = in_valid & in_ready;
    data_d[0]  = mix_w;
    tag_d[0]   = tag_in;
`ifdef DES_EXP_PARITY_EN
    par_d[0]   = ^mix_w;
`endif
    for (int i = 1; i < DEPTH; i++) begin
      valid_d[i] = valid_q[i-1];
      data_d[i]  = data_q[i-1];
      tag_d[i]   = tag_q[i-1];
`ifdef DES_EXP_PARITY_EN
      par_d[i]   = par_q[i-1];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
`ifdef DES_EXP_PARITY_EN
      par_q   <= '0;
`endif
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        tag_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (load[i]) begin
          valid_q[i] <= valid_d[i];
          if (valid_d[i]) begin
            data_q[i] <= data_d[i];
            tag_q[i]  <= tag_d[i];
`ifdef DES_EXP_PARITY_EN
            par_q[i]  <= par_d[i];
`endif
          end
        end
      end
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign data_out  = {data_q[DEPTH-1], 1'b0};
  assign tag_out   = tag_q[DEPTH-1];
  assign busy      = |valid_q;
`ifdef DES_EXP_PARITY_EN
  assign par_out   = par_q[DEPTH-1];
`endif

endmodule
